hdmi_video_timing: RTL and testbench

//  Parametrised CEA-861 video timing generator; successor to the fixed 720x480 counters in hdmi_tx.

---
 rtl/hdmi_video_timing_pkg.sv | 19 +
 rtl/hdmi_video_timing_if.sv | 31 +++
 rtl/hdmi_video_timing_counter.sv | 23 ++
 rtl/hdmi_video_timing.sv | 115 +++++++++++
 tb/tb_hdmi_video_timing.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/hdmi_video_timing_pkg.sv
// Shared types and constants for the CEA-861 video timing generator.
// Period codes match the HDMI data-island-free video signalling.
package hdmi_timing_pkg;

    typedef enum logic [1:0] {
        CONTROL        = 2'd0,
        VIDEO_PREAMBLE = 2'd1,
        VIDEO_GUARD    = 2'd2,
        VIDEO_DATA     = 2'd3
    } periodType_e;

    localparam logic [3:0] CTL_VIDEO_PREAMBLE = 4'b0001;
    localparam logic [3:0] CTL_IDLE           = 4'b0000;

    localparam int PREAMBLE_LEN = 8;
    localparam int GUARD_LEN    = 2;
    localparam int CTRL_MIN_LEN = 12;

endpackage

// File: rtl/hdmi_video_timing_if.sv
// Timing bundle between the generator (master) and its consumers (slave).
// enable flows from the consumer side; everything else is produced by the generator.
interface hdmi_video_timing_if
    import hdmi_timing_pkg::*;
#(
    parameter int H_CNT_W = 10,
    parameter int V_CNT_W = 10
);
    logic               enable;
    logic [H_CNT_W-1:0] hPos;
    logic [V_CNT_W-1:0] vPos;
    logic               hSync;
    logic               vSync;
    logic               DE;
    periodType_e        periodType;
    logic [3:0]         ctl;
    logic               lineStart;
    logic               frameStart;

    modport master (
        input  enable,
        output hPos, vPos, hSync, vSync, DE,
        output periodType, ctl, lineStart, frameStart
    );

    modport slave (
        output enable,
        input  hPos, vPos, hSync, vSync, DE,
        input  periodType, ctl, lineStart, frameStart
    );
endinterface

// File: rtl/hdmi_video_timing_counter.sv
// Wrapping counter 0..MAX with enable and terminal-count flag.
// Used for both the horizontal and vertical raster positions.
module timing_counter #(
    parameter int MAX = 857,
    parameter int W   = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         tc
);
    localparam logic [W-1:0] LAST = W'(MAX);

    assign tc = (count == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else if (en)
            count <= tc ? '0 : count + 1'b1;
    end
endmodule

// File: rtl/hdmi_video_timing.sv
// Parametrised CEA-861 timing generator with registered, mutually aligned outputs.
// Define HDMI_PREAMBLE_EN for HDMI preamble/guard signalling; otherwise DVI mode.
module hdmi_video_timing
    import hdmi_timing_pkg::*;
#(
    parameter int H_ACTIVE  = 720,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 62,
    parameter int H_BACK    = 60,
    parameter int V_ACTIVE  = 480,
    parameter int V_FRONT   = 9,
    parameter int V_SYNC    = 6,
    parameter int V_BACK    = 30,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0,
    parameter int H_CNT_W   = 10,
    parameter int V_CNT_W   = 10
) (
    input logic                  pixelClock,
    input logic                  reset,
    hdmi_video_timing_if.master  vif
);
    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [H_CNT_W-1:0] H_ACT  = H_CNT_W'(H_ACTIVE);
    localparam logic [H_CNT_W-1:0] HS_BEG = H_CNT_W'(H_ACTIVE + H_FRONT);
    localparam logic [H_CNT_W-1:0] HS_END = H_CNT_W'(H_ACTIVE + H_FRONT + H_SYNC - 1);
    localparam logic [H_CNT_W-1:0] PR_BEG = H_CNT_W'(H_TOTAL - GUARD_LEN - PREAMBLE_LEN);
    localparam logic [H_CNT_W-1:0] PR_END = H_CNT_W'(H_TOTAL - GUARD_LEN - 1);
    localparam logic [H_CNT_W-1:0] GD_BEG = H_CNT_W'(H_TOTAL - GUARD_LEN);
    localparam logic [V_CNT_W-1:0] V_ACT  = V_CNT_W'(V_ACTIVE);
    localparam logic [V_CNT_W-1:0] V_ACT1 = V_CNT_W'(V_ACTIVE - 1);
    localparam logic [V_CNT_W-1:0] VS_BEG = V_CNT_W'(V_ACTIVE + V_FRONT);
    localparam logic [V_CNT_W-1:0] VS_END = V_CNT_W'(V_ACTIVE + V_FRONT + V_SYNC - 1);

    generate
        if (H_BACK < CTRL_MIN_LEN) begin : g_ctrlMinCheck
            $error("hdmi_video_timing: H_BACK too short for the control period");
        end
    endgenerate

    logic [H_CNT_W-1:0] h;
    logic [V_CNT_W-1:0] v;
    logic               hTc;
    logic               vTc;

    timing_counter #(.MAX(H_TOTAL - 1), .W(H_CNT_W)) hCounter (
        .clk(pixelClock), .rst(reset), .en(vif.enable),
        .count(h), .tc(hTc)
    );

    timing_counter #(.MAX(V_TOTAL - 1), .W(V_CNT_W)) vCounter (
        .clk(pixelClock), .rst(reset), .en(vif.enable && hTc),
        .count(v), .tc(vTc)
    );

    logic        deN;
    logic        hsN;
    logic        vsN;
    logic        nla;
    periodType_e ptN;
    logic [3:0]  ctlN;

    // Next line carries video: the preamble/guard lead into the following line.
    assign nla = vTc || (v < V_ACT1);

`ifndef HDMI_PREAMBLE_EN
    logic unusedNla;
    assign unusedNla = nla;
`endif

    always_comb begin
        deN  = (h < H_ACT) && (v < V_ACT);
        hsN  = ((h >= HS_BEG) && (h <= HS_END)) ? HSYNC_POL : ~HSYNC_POL;
        vsN  = ((v >= VS_BEG) && (v <= VS_END)) ? VSYNC_POL : ~VSYNC_POL;
        ptN  = CONTROL;
        ctlN = CTL_IDLE;
        if (deN) begin
            ptN = VIDEO_DATA;
        end
`ifdef HDMI_PREAMBLE_EN
        else if (nla && (h >= GD_BEG)) begin
            ptN = VIDEO_GUARD;
        end else if (nla && (h >= PR_BEG) && (h <= PR_END)) begin
            ptN  = VIDEO_PREAMBLE;
            ctlN = CTL_VIDEO_PREAMBLE;
        end
`endif
    end

    always_ff @(posedge pixelClock or posedge reset) begin
        if (reset) begin
            vif.hPos       <= '0;
            vif.vPos       <= '0;
            vif.DE         <= 1'b0;
            vif.hSync      <= ~HSYNC_POL;
            vif.vSync      <= ~VSYNC_POL;
            vif.periodType <= CONTROL;
            vif.ctl        <= CTL_IDLE;
            vif.lineStart  <= 1'b0;
            vif.frameStart <= 1'b0;
        end else if (vif.enable) begin
            vif.hPos       <= h;
            vif.vPos       <= v;
            vif.DE         <= deN;
            vif.hSync      <= hsN;
            vif.vSync      <= vsN;
            vif.periodType <= ptN;
            vif.ctl        <= ctlN;
            vif.lineStart  <= (h == '0);
            vif.frameStart <= (h == '0) && (v == '0);
        end
    end
endmodule

// File: tb/tb_hdmi_video_timing.sv
// Randomised-enable bench for hdmi_video_timing against a raster-rule model.
// Default horizontal timing; shortened vertical timing keeps whole frames affordable.
module tb_hdmi_video_timing;
    localparam int HA = 720, HF = 16, HS = 62, HB = 60;
    localparam int VA = 20, VF = 2, VS = 3, VB = 5;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;

    typedef struct {
        int h; int v;
        bit hs; bit vs; bit de;
        int pt; int ctl;
        bit ls; bit fs;
    } exp_t;

    logic pixelClock = 1'b0;
    logic reset = 1'b1;

    hdmi_video_timing_if #(.H_CNT_W(10), .V_CNT_W(10)) vif ();

    hdmi_video_timing #(
        .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b0),
        .H_CNT_W(10), .V_CNT_W(10)
    ) dut (
        .pixelClock(pixelClock),
        .reset(reset),
        .vif(vif.master)
    );

    always #5 pixelClock = ~pixelClock;

    int checks = 0;
    int failures = 0;
    int mh = 0, mv = 0;
    int enCount = 0;
    int lastFs = -1;
    int cyc = 0;
    exp_t cur;

    function automatic exp_t decode(int h, int v);
        exp_t e;
        bit nla;
        e.h = h; e.v = v;
        e.de = (h < HA) && (v < VA);
        e.hs = !((h >= HA + HF) && (h < HA + HF + HS));
        e.vs = !((v >= VA + VF) && (v < VA + VF + VS));
        e.ls = (h == 0);
        e.fs = (h == 0) && (v == 0);
        e.pt = 0; e.ctl = 0;
        nla = (v == VT - 1) || (v < VA - 1);
        if (e.de) e.pt = 3;
`ifdef HDMI_PREAMBLE_EN
        else if (nla && h >= HT - 2) e.pt = 2;
        else if (nla && h >= HT - 10 && h <= HT - 3) begin
            e.pt = 1; e.ctl = 1;
        end
`endif
        return e;
    endfunction

    function automatic exp_t resetVals();
        exp_t e;
        e = '{h:0, v:0, hs:1, vs:1, de:0, pt:0, ctl:0, ls:0, fs:0};
        return e;
    endfunction

    task automatic pin(string name, int got, int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic compare();
        exp_t g;
        g.h = int'(vif.hPos); g.v = int'(vif.vPos);
        g.hs = vif.hSync; g.vs = vif.vSync; g.de = vif.DE;
        g.pt = int'(vif.periodType); g.ctl = int'(vif.ctl);
        g.ls = vif.lineStart; g.fs = vif.frameStart;
        checks++;
        if (g != cur) begin
            failures++;
            $display("FAIL outputs cyc=%0d got h=%0d v=%0d hs=%0b vs=%0b de=%0b pt=%0d ctl=%0d ls=%0b fs=%0b want h=%0d v=%0d hs=%0b vs=%0b de=%0b pt=%0d ctl=%0d ls=%0b fs=%0b",
                     cyc, g.h, g.v, g.hs, g.vs, g.de, g.pt, g.ctl, g.ls, g.fs,
                     cur.h, cur.v, cur.hs, cur.vs, cur.de, cur.pt, cur.ctl, cur.ls, cur.fs);
        end
    endtask

    task automatic step(bit rstIn, bit enIn);
        @(negedge pixelClock);
        reset = rstIn;
        vif.enable = enIn;
        @(posedge pixelClock);
        #1;
        cyc++;
        if (rstIn) begin
            cur = resetVals();
            mh = 0; mv = 0;
            lastFs = -1;
        end else if (enIn) begin
            cur = decode(mh, mv);
            if (cur.fs) begin
                if (lastFs >= 0) pin("framePeriod", enCount - lastFs, HT * VT);
                lastFs = enCount;
            end
            enCount++;
            mh++;
            if (mh == HT) begin
                mh = 0;
                mv = (mv == VT - 1) ? 0 : mv + 1;
            end
        end
        compare();
    endtask

    initial begin
        exp_t e;
        vif.enable = 1'b0;
        cur = resetVals();

        e = decode(736, 5);  pin("hSyncFirst", e.hs, 0);
        e = decode(797, 5);  pin("hSyncLast", e.hs, 0);
        e = decode(735, 5);  pin("hSyncBefore", e.hs, 1);
        e = decode(798, 5);  pin("hSyncAfter", e.hs, 1);
        e = decode(0, 22);   pin("vSyncFirst", e.vs, 0);
        e = decode(0, 25);   pin("vSyncAfter", e.vs, 1);
        e = decode(719, 0);  pin("deLast", e.de, 1);
        e = decode(720, 0);  pin("deOff", e.de, 0);
        e = decode(848, VA - 1); pin("ptLastActive", e.pt, 0);
`ifdef HDMI_PREAMBLE_EN
        e = decode(848, VT - 1); pin("ptPreamble", e.pt, 1);
        pin("ctlPreamble", e.ctl, 1);
        e = decode(855, 3);  pin("ptPreEnd", e.pt, 1);
        e = decode(856, VT - 1); pin("ptGuard", e.pt, 2);
        e = decode(857, VT - 1); pin("ctlGuard", e.ctl, 0);
`else
        e = decode(848, VT - 1); pin("ptDvi", e.pt, 0);
        pin("ctlDvi", e.ctl, 0);
`endif

        repeat (3) step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        pin("firstH", int'(vif.hPos), 0);
        pin("firstDE", int'(vif.DE), 1);
        pin("firstFs", int'(vif.frameStart), 1);
        pin("firstLs", int'(vif.lineStart), 1);
        step(1'b0, 1'b1);
        pin("secondH", int'(vif.hPos), 1);
        pin("secondLs", int'(vif.lineStart), 0);

        while (cur.h != 100) step(1'b0, 1'b1);
        repeat (5) step(1'b0, 1'b0);
        pin("holdH", int'(vif.hPos), 100);
        step(1'b0, 1'b1);
        pin("resumeH", int'(vif.hPos), 101);

        while (cur.h != 300) step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        pin("midResetH", int'(vif.hPos), 0);
        step(1'b0, 1'b1);
        pin("restartFs", int'(vif.frameStart), 1);

        while (enCount < 2 * HT * VT + 50 && cyc < 90000)
            step(1'b0, $urandom_range(0, 9) != 0);
        pin("enabledBudget", int'(enCount >= 2 * HT * VT + 50), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
